// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one external pipelined multiplier between two
// requesters; a valid/owner tag pipe matched to the multiplier depth routes products back.
module mul_share_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAT   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic [WIDTH-1:0]         a0,
  input  logic [WIDTH-1:0]         b0,
  output logic                     gnt0,
  input  logic                     req1,
  input  logic [WIDTH-1:0]         a1,
  input  logic [WIDTH-1:0]         b1,
  output logic                     gnt1,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     rsp_valid0,
  output logic                     rsp_valid1,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic [$clog2(LAT+1)-1:0] inflight
);

  localparam int unsigned CW = $clog2(LAT+1);

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

  owner_e           last_q, last_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [LAT-1:0]   own_q, own_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             issue;
  logic             retire;

  // On contention the requester not granted most recently wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || last_q == OWN1)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    issue      = gnt0 | gnt1;
    retire     = vld_q[LAT-1];
    last_d     = last_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    inflight_d = inflight_q;
    vld_d      = '0;
    own_d      = '0;

    if (gnt0) begin
      last_d  = OWN0;
      mul_a_d = a0;
      mul_b_d = b0;
    end else if (gnt1) begin
      last_d  = OWN1;
      mul_a_d = a1;
      mul_b_d = b1;
    end

    vld_d[0] = issue;
    own_d[0] = gnt1;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end

    if (issue && !retire) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue && retire) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= OWN1;
      vld_q      <= '0;
      own_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      inflight_q <= '0;
    end else begin
      last_q     <= last_d;
      vld_q      <= vld_d;
      own_q      <= own_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      inflight_q <= inflight_d;
    end
  end

  // Strobes are masked during reset so tags from before reset never surface.
  assign rsp_valid0 = !rst && vld_q[LAT-1] && (own_q[LAT-1] == OWN0);
  assign rsp_valid1 = !rst && vld_q[LAT-1] && (own_q[LAT-1] == OWN1);
  assign rsp_data   = mul_p;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign inflight   = inflight_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Random and scripted stimulus for mul_share_arbiter checked against a cycle-indexed
// reference of grants and scheduled responses; the bench also models the multiplier.
module tb_mul_share_arbiter;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = 3;
  localparam int NCYC = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic              gnt0, gnt1;
  logic [WIDTH-1:0]  mul_a, mul_b;
  logic [31:0]       mul_p;
  logic              rsp_valid0, rsp_valid1;
  logic [31:0]       rsp_data;
  logic [1:0]        inflight;

  mul_share_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_data(rsp_data),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // External multiplier: mul_a/mul_b register is the first of LAT stages.
  logic [31:0] mp0 = '0, mp1 = '0;
  always_ff @(posedge clk) begin
    mp0 <= 32'(mul_a) * 32'(mul_b);
    mp1 <= mp0;
  end
  assign mul_p = mp1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference state, indexed by absolute cycle number.
  int          t = 0;
  int          last_rst = -1;
  int          m_last = 1;
  logic [15:0] m_mul_a = '0, m_mul_b = '0;
  bit          g_hist [NCYC];
  bit          e_vld  [NCYC + LAT + 1];
  int          e_own  [NCYC + LAT + 1];
  logic [31:0] e_dat  [NCYC + LAT + 1];

  task automatic cycle(input bit r, input bit q0, input logic [15:0] x0, input logic [15:0] y0,
                       input bit q1, input logic [15:0] x1, input logic [15:0] y1,
                       output bit g0, output bit g1);
    int cnt;
    rst = r; req0 = q0; a0 = x0; b0 = y0; req1 = q1; a1 = x1; b1 = y1;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (r) begin
      chk("gnt0_rst", 32'(gnt0), 32'd0);
      chk("gnt1_rst", 32'(gnt1), 32'd0);
      chk("rsp_valid0_rst", 32'(rsp_valid0), 32'd0);
      chk("rsp_valid1_rst", 32'(rsp_valid1), 32'd0);
      m_last = 1;
      m_mul_a = '0;
      m_mul_b = '0;
      last_rst = t;
      for (int k = 1; k <= int'(LAT); k++) e_vld[t + k] = 1'b0;
    end else begin
      g0 = q0 && (!q1 || m_last == 1);
      g1 = q1 && !g0;
      cnt = 0;
      for (int c = t - int'(LAT); c < t; c++)
        if (c > last_rst && c >= 0 && g_hist[c]) cnt++;
      chk("gnt0", 32'(gnt0), 32'(g0));
      chk("gnt1", 32'(gnt1), 32'(g1));
      chk("mul_a", 32'(mul_a), 32'(m_mul_a));
      chk("mul_b", 32'(mul_b), 32'(m_mul_b));
      chk("inflight", 32'(inflight), 32'(cnt));
      chk("rsp_valid0", 32'(rsp_valid0), 32'(e_vld[t] && e_own[t] == 0));
      chk("rsp_valid1", 32'(rsp_valid1), 32'(e_vld[t] && e_own[t] == 1));
      if (e_vld[t]) chk("rsp_data", rsp_data, e_dat[t]);
      if (g0 || g1) begin
        m_last  = g0 ? 0 : 1;
        m_mul_a = g0 ? x0 : x1;
        m_mul_b = g0 ? y0 : y1;
        g_hist[t] = 1'b1;
        e_vld[t + LAT] = 1'b1;
        e_own[t + LAT] = m_last;
        e_dat[t + LAT] = 32'(m_mul_a) * 32'(m_mul_b);
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
  endtask

  task automatic do_reset(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom % 4)
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit g0, g1;
    bit p0, p1;
    logic [15:0] pa0, pb0, pa1, pb1;
    logic [15:0] s0a [2], s0b [2], s1a [2], s1b [2];
    int i0, i1, guard;

    for (int k = 0; k < NCYC; k++) g_hist[k] = 1'b0;
    for (int k = 0; k < NCYC + int'(LAT) + 1; k++) begin
      e_vld[k] = 1'b0; e_own[k] = 0; e_dat[k] = '0;
    end
    @(posedge clk);
    #1;
    do_reset(2);

    // Largest operands: full 32-bit product.
    cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, '0, '0, g0, g1);
    idle(LAT + 1);

    // Both requesters held: grants alternate starting with requester 0.
    do_reset(1);
    s0a = '{16'd3, 16'd7};   s0b = '{16'd5, 16'd9};
    s1a = '{16'd100, 16'd12}; s1b = '{16'd200, 16'd12};
    i0 = 0; i1 = 0; guard = 0;
    while ((i0 < 2 || i1 < 2) && guard < 20) begin
      cycle(1'b0, i0 < 2, s0a[i0 % 2], s0b[i0 % 2], i1 < 2, s1a[i1 % 2], s1b[i1 % 2], g0, g1);
      if (g0) i0++;
      if (g1) i1++;
      guard++;
    end
    if (guard >= 20) chk("alternate_budget", 32'(guard), 32'd0);
    idle(LAT + 1);

    // Requester 1 back-to-back: inflight saturates at LAT with same-edge issue/return.
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 16'(k + 1), 16'(1000 + k), g0, g1);
    idle(LAT + 2);

    // Bubble between two issues.
    cycle(1'b0, 1'b1, 16'd11, 16'd13, 1'b0, '0, '0, g0, g1);
    idle(1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 16'd17, 16'd19, g0, g1);
    idle(LAT + 1);

    // Reset with two operations in flight, then contention must favour requester 0.
    cycle(1'b0, 1'b1, 16'd21, 16'd23, 1'b0, '0, '0, g0, g1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 16'd25, 16'd27, g0, g1);
    do_reset(1);
    cycle(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 16'd4, 16'd5, g0, g1);
    idle(LAT + 1);

    // Random traffic with hold-until-grant, withdrawals and occasional reset.
    p0 = 1'b0; p1 = 1'b0;
    pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!p0 && ($urandom % 3) != 0) begin p0 = 1'b1; pa0 = rand_op(); pb0 = rand_op(); end
      else if (p0 && ($urandom % 16) == 0) p0 = 1'b0;
      if (!p1 && ($urandom % 3) != 0) begin p1 = 1'b1; pa1 = rand_op(); pb1 = rand_op(); end
      else if (p1 && ($urandom % 16) == 0) p1 = 1'b0;
      if (($urandom % 97) == 0) begin
        do_reset(1);
      end else begin
        cycle(1'b0, p0, pa0, pb0, p1, pa1, pb1, g0, g1);
        if (g0) p0 = 1'b0;
        if (g1) p1 = 1'b0;
      end
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
